// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port memory.
// Fetch and load/store share one outstanding slot.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t     state;
  logic       last_d;
  logic [7:0] wdog;
  logic       busy_i;
  logic       busy_d;
  logic       tmo;

  assign busy_i = (state == BUSY_I);
  assign busy_d = (state == BUSY_D);
  assign tmo    = (wdog == 8'hff) && !m_ack;

  assign i_ack   = !rst && busy_i && m_ack;
  assign i_err   = !rst && busy_i && tmo;
  assign d_ack   = !rst && busy_d && m_ack;
  assign d_err   = !rst && busy_d && tmo;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign m_req = busy_i || busy_d;
  assign grant = {busy_d, busy_i};

  // Arbitrate, latch the winner's request, run the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_d  <= 1'b1;
      wdog    <= 8'd0;
      m_we    <= 1'b0;
      m_addr  <= 32'd0;
      m_wdata <= 32'd0;
      m_wstrb <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req && (!d_req || last_d)) begin
            state   <= BUSY_I;
            last_d  <= 1'b0;
            wdog    <= 8'd0;
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= 32'd0;
            m_wstrb <= 4'd0;
          end else if (d_req) begin
            state   <= BUSY_D;
            last_d  <= 1'b1;
            wdog    <= 8'd0;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_wstrb <= d_wstrb;
          end
        end
        BUSY_I, BUSY_D: begin
          if (m_ack || wdog == 8'hff) begin
            state <= IDLE;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// Inputs change 1ns after posedge; checks follow a settle delay.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk    (clk),
    .rst    (rst),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_ack  (i_ack),
    .i_rdata(i_rdata),
    .i_err  (i_err),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .d_wstrb(d_wstrb),
    .d_ack  (d_ack),
    .d_rdata(d_rdata),
    .d_err  (d_err),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_ack  (m_ack),
    .m_rdata(m_rdata),
    .grant  (grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic no_resp(input string tag);
    chk({tag, "_resp"}, {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
  endtask

  int bad;
  logic [1:0] exp_g [4];

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0;
    m_ack = 0; m_rdata = 32'hA5A5_5A5A;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_mreq", m_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_maddr", m_addr, 0);
    chk("rst_mwe", m_we, 0);
    chk("rst_mwdata", m_wdata, 0);
    chk("rst_mwstrb", m_wstrb, 0);
    no_resp("rst");

    // spurious m_ack in IDLE
    m_ack = 1'b1;
    settle();
    no_resp("idle_ack");
    tick();
    m_ack = 1'b0;
    settle();
    chk("idle_ack_mreq", m_req, 0);
    chk("idle_ack_grant", grant, 0);

    // single fetch, memory latency 2
    i_req = 1'b1; i_addr = 32'h100;
    settle();
    chk("f_mreq_c0", m_req, 0);
    tick();
    chk("f_mreq", m_req, 1);
    chk("f_grant", grant, 2'b01);
    chk("f_maddr", m_addr, 32'h100);
    chk("f_mwe", m_we, 0);
    chk("f_mwstrb", m_wstrb, 0);
    tick();
    tick();
    no_resp("f_wait");
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    settle();
    chk("f_iack", i_ack, 1);
    chk("f_irdata", i_rdata, 32'hDEAD_BEEF);
    chk("f_other", {i_err, d_ack, d_err}, 0);
    tick();
    i_req = 1'b0; m_ack = 1'b0;
    settle();
    chk("f_iack_done", i_ack, 0);
    chk("f_grant_done", grant, 0);
    chk("f_mreq_done", m_req, 0);

    // simultaneous requests alternate I, D, I, D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h180;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10;
    exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("alt_grant%0d", k), grant, exp_g[k]);
      chk($sformatf("alt_addr%0d", k), m_addr,
          exp_g[k] == 2'b01 ? 32'h180 : 32'h300);
      m_ack = 1'b1; m_rdata = 32'h1000 + k;
      settle();
      chk($sformatf("alt_ack%0d", k),
          {i_ack, d_ack}, exp_g[k] == 2'b01 ? 2'b10 : 2'b01);
      chk($sformatf("alt_rd%0d", k),
          exp_g[k] == 2'b01 ? i_rdata : d_rdata, 32'h1000 + k);
      tick();
      m_ack = 1'b0;
      settle();
      chk($sformatf("alt_idle%0d", k), grant, 0);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // store with stable request fields
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
    d_wdata = 32'h1234_5678; d_wstrb = 4'b0011;
    tick();
    d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'b1111;
    d_addr = 32'hFFF0; d_we = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (m_we !== 1'b1 || m_wstrb !== 4'b0011 ||
          m_addr !== 32'h200 || m_wdata !== 32'h1234_5678 ||
          grant !== 2'b10 || m_req !== 1'b1 ||
          d_ack !== 1'b0)
        bad++;
      tick();
    end
    chk("st_stable_bad", bad, 0);
    m_ack = 1'b1;
    settle();
    chk("st_dack", d_ack, 1);
    chk("st_other", {i_ack, i_err, d_err}, 0);
    tick();
    d_req = 1'b0; m_ack = 1'b0;
    settle();
    chk("st_done", {28'd0, m_req, d_ack, grant}, 0);

    // watchdog timeout on a load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    tick();
    chk("wd_grant", grant, 2'b10);
    bad = 0;
    for (int k = 1; k < 255; k++) begin
      tick();
      if (d_err !== 1'b0 || m_req !== 1'b1) bad++;
    end
    chk("wd_early_bad", bad, 0);
    tick();
    chk("wd_derr", d_err, 1);
    chk("wd_mreq_hold", m_req, 1);
    chk("wd_other", {i_ack, i_err, d_ack}, 0);
    d_req = 1'b0;
    tick();
    chk("wd_mreq_drop", m_req, 0);
    chk("wd_derr_pulse", d_err, 0);
    chk("wd_grant_idle", grant, 0);
    i_req = 1'b1; i_addr = 32'h500;
    tick();
    chk("wd_new_grant", grant, 2'b01);
    chk("wd_new_addr", m_addr, 32'h500);

    // ack on the timeout cycle wins over err
    bad = 0;
    for (int k = 1; k < 255; k++) begin
      tick();
      if (i_err !== 1'b0) bad++;
    end
    chk("race_early_bad", bad, 0);
    tick();
    m_ack = 1'b1; m_rdata = 32'hCAFE_F00D;
    settle();
    chk("race_iack", i_ack, 1);
    chk("race_ierr", i_err, 0);
    chk("race_rdata", i_rdata, 32'hCAFE_F00D);
    tick();
    i_req = 1'b0; m_ack = 1'b0;
    settle();
    chk("race_done", {30'd0, grant}, 0);

    // reset three cycles into a fetch
    i_req = 1'b1; i_addr = 32'h600;
    tick();
    tick();
    tick();
    tick();
    chk("mid_busy", grant, 2'b01);
    rst = 1'b1; m_ack = 1'b1;
    settle();
    no_resp("mid_rst");
    tick();
    rst = 1'b0; m_ack = 1'b0;
    i_req = 1'b0;
    settle();
    chk("mid_mreq", m_req, 0);
    chk("mid_grant", grant, 0);
    chk("mid_maddr", m_addr, 0);
    no_resp("mid_after");
    i_req = 1'b1; i_addr = 32'h700;
    d_req = 1'b1; d_addr = 32'h800;
    tick();
    chk("mid_tie_grant", grant, 2'b01);
    chk("mid_tie_addr", m_addr, 32'h700);
    i_req = 1'b0; d_req = 1'b0;
    m_ack = 1'b1;
    settle();
    chk("mid_tie_ack", i_ack, 1);
    tick();
    m_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
